// File: rtl/issue_scoreboard.sv
// Issue scoreboard: physical-register ready bits plus busy countdowns for ALU0, ALU1 and LSU.
// The reservation station reads the ready vector and the FU availability mask each cycle.
module issue_scoreboard #(
    parameter int unsigned NPREG   = 64,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned LSU_LAT = 3,
    parameter int unsigned CW      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                disp_we_1,
    input  logic [5:0]          disp_rd_1,
    input  logic                disp_we_2,
    input  logic [5:0]          disp_rd_2,
    input  logic [2:0]          wb_valid,
    input  logic [5:0]          wb_rd_0,
    input  logic [5:0]          wb_rd_1,
    input  logic [5:0]          wb_rd_2,
    input  logic [2:0]          issue_valid,
    input  logic                mem_stall,
    output logic [NPREG-1:0]    reg_ready,
    output logic [2:0]          func_units,
    output logic [3*CW-1:0]     fu_busy_cnt,
    output logic                issue_err,
    output logic [6:0]          pending_cnt
);

    localparam int unsigned     PW       = 6;
    localparam int unsigned     NFU      = 3;
    localparam logic [CW-1:0]   ALU_LOAD = CW'(ALU_LAT - 1);
    localparam logic [CW-1:0]   LSU_LOAD = CW'(LSU_LAT - 1);

    logic [NPREG-1:0] r_ready;
    logic [NPREG-1:0] w_ready_nxt;
    logic [6:0]       r_pend;
    logic [6:0]       w_pend_nxt;
    logic [CW-1:0]    r_cnt     [NFU];
    logic [CW-1:0]    w_cnt_nxt [NFU];
    logic [CW-1:0]    w_load    [NFU];
    logic [PW-1:0]    w_wb_rd   [NFU];
    logic [NFU-1:0]   w_fu_free;
    logic             w_err;
    logic             r_err;

    // Writeback sets first, dispatch clears after so reallocation wins; preg 0 is pinned ready.
    always_comb begin
        w_wb_rd[0]  = wb_rd_0;
        w_wb_rd[1]  = wb_rd_1;
        w_wb_rd[2]  = wb_rd_2;
        w_ready_nxt = r_ready;
        for (int unsigned k = 0; k < NFU; k++) begin
            if (wb_valid[k]) w_ready_nxt[w_wb_rd[k]] = 1'b1;
        end
        if (disp_we_1) w_ready_nxt[disp_rd_1] = 1'b0;
        if (disp_we_2) w_ready_nxt[disp_rd_2] = 1'b0;
        w_ready_nxt[0] = 1'b1;
        w_pend_nxt = '0;
        for (int unsigned i = 0; i < NPREG; i++) begin
            w_pend_nxt = w_pend_nxt + 7'(!w_ready_nxt[i]);
        end
    end

    // FU countdowns: load on a legal issue, otherwise count down (LSU frozen by mem_stall).
    always_comb begin
        w_load[0] = ALU_LOAD;
        w_load[1] = ALU_LOAD;
        w_load[2] = LSU_LOAD;
        w_err     = 1'b0;
        for (int unsigned k = 0; k < NFU; k++) begin
            w_fu_free[k] = (r_cnt[k] == '0);
            w_cnt_nxt[k] = r_cnt[k];
            if (issue_valid[k] && w_fu_free[k]) begin
                w_cnt_nxt[k] = w_load[k];
            end else if (!w_fu_free[k] && !(k == 2 && mem_stall)) begin
                w_cnt_nxt[k] = r_cnt[k] - CW'(1);
            end
            if (issue_valid[k] && !w_fu_free[k]) w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= '1;
            r_pend  <= '0;
            r_err   <= 1'b0;
            for (int unsigned k = 0; k < NFU; k++) r_cnt[k] <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_err;
            for (int unsigned k = 0; k < NFU; k++) r_cnt[k] <= w_cnt_nxt[k];
        end
    end

    assign reg_ready   = r_ready;
    assign pending_cnt = r_pend;
    assign issue_err   = r_err;
    assign func_units  = w_fu_free;
    assign fu_busy_cnt = {r_cnt[2], r_cnt[1], r_cnt[0]};

endmodule
